// File: rtl/mem_stream_merger_if.sv
// Read-port and merged-output bus of mem_stream_merger.
// The master side is the merger; the slave side is memory plus consumer.
interface mem_stream_merger_if #(
  parameter int DW = 32,
  parameter int AW = 6
);
  logic          rd_en;
  logic [3:0]    rd_blk;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] dout;
  logic [3:0]    dout_blk;
  logic          dout_valid;
  logic          dout_last;
  logic          dout_ready;

  modport master (
    output rd_en, rd_blk, rd_addr, dout, dout_blk, dout_valid, dout_last,
    input  rd_data, dout_ready
  );
  modport slave (
    input  rd_en, rd_blk, rd_addr, dout, dout_blk, dout_valid, dout_last,
    output rd_data, dout_ready
  );
endinterface

// File: rtl/mem_stream_merger.sv
// Drains NBLK memory blocks in priority order into one tagged stream.
// A credit check on FIFO occupancy plus in-flight reads keeps the 2-deep FIFO from overflowing.
module mem_stream_merger #(
  parameter int NBLK = 12,
  parameter int DW   = 32,
  parameter int AW   = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NBLK*(AW+1)-1:0] nent,
  mem_stream_merger_if.master    bus,
  output logic                   busy,
  output logic                   done
);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] MAXC = CW'(1) << AW;

  typedef enum logic [1:0] {IDLE, SCAN, READ, DONE} state_e;
  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    blk;
    logic          last;
  } ent_t;

  state_e                  state_q, state_d;
  logic [NBLK-1:0][CW-1:0] cnt_q, nent_c;
  logic [NBLK-1:0]         served_q;
  logic [3:0]              sel_q, pick;
  logic [AW-1:0]           addr_q;
  logic                    lastblk_q, found, more, fin;
  logic                    infl_q, infl_last_q;
  logic [3:0]              infl_blk_q;
  ent_t                    mem_q [2];
  logic                    wp_q, rp_q;
  logic [1:0]              occ_q;
  logic                    push, pop, drained, pop_last;

  always_comb begin
    for (int k = 0; k < NBLK; k++) begin
      nent_c[k] = nent[k*CW +: CW];
      if (nent_c[k] > MAXC) nent_c[k] = MAXC;
    end
  end

  // Lowest pending block wins; 'more' tells whether it is the event's final block.
  always_comb begin
    found = 1'b0;
    more  = 1'b0;
    pick  = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (!served_q[k] && cnt_q[k] != '0) begin
        if (found) more = 1'b1;
        else begin
          found = 1'b1;
          pick  = 4'(k);
        end
      end
    end
  end

  assign fin        = ({1'b0, addr_q} == cnt_q[sel_q] - CW'(1));
  assign bus.rd_en  = (state_q == READ) && ((occ_q + {1'b0, infl_q}) < 2'd2);
  assign bus.rd_blk = sel_q;
  assign bus.rd_addr = addr_q;

  assign push     = infl_q;
  assign pop      = bus.dout_valid && bus.dout_ready;
  assign drained  = (occ_q == 2'd0) && !infl_q;
  assign pop_last = pop && bus.dout_last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: state_d = IDLE;
      SCAN: begin
        if (found) state_d = READ;
        // Hold here until the last word has been handed to the consumer.
        else if (drained || pop_last) state_d = DONE;
      end
      READ: if (bus.rd_en && fin) state_d = SCAN;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = SCAN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      served_q  <= '0;
      sel_q     <= '0;
      addr_q    <= '0;
      lastblk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q    <= nent_c;
        served_q <= '0;
        addr_q   <= '0;
      end else if (state_q == SCAN && found) begin
        sel_q     <= pick;
        addr_q    <= '0;
        lastblk_q <= !more;
      end else if (bus.rd_en) begin
        if (fin) served_q[sel_q] <= 1'b1;
        else     addr_q <= addr_q + AW'(1);
      end
    end
  end

  // Clearing the in-flight flag on start drops data still returning for an aborted event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      infl_q      <= 1'b0;
      infl_blk_q  <= '0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= bus.rd_en && !start;
      infl_blk_q  <= sel_q;
      infl_last_q <= lastblk_q && fin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= 2'd0;
    end else if (start) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= {bus.rd_data, infl_blk_q, infl_last_q};
        wp_q        <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign bus.dout       = mem_q[rp_q].data;
  assign bus.dout_blk   = mem_q[rp_q].blk;
  assign bus.dout_valid = (occ_q != 2'd0);
  assign bus.dout_last  = bus.dout_valid && mem_q[rp_q].last;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_mem_stream_merger.sv
// Directed bench for mem_stream_merger: priority order, latency, back-pressure,
// count clamping, mid-event restart and asynchronous reset.
module tb_mem_stream_merger;
  localparam int NBLK = 12, DW = 32, AW = 6, CW = AW + 1;

  logic                 clk = 1'b0;
  logic                 rst_n, start, busy, done;
  logic [NBLK*CW-1:0]   nent;
  int                   n_cmp = 0, n_err = 0;
  int                   cyc = 0;

  mem_stream_merger_if #(.DW(DW), .AW(AW)) bus ();

  mem_stream_merger #(.NBLK(NBLK), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nent(nent),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] mk(input logic [3:0] b, input logic [5:0] a);
    return {16'hA5C3, 4'h0, b, 2'b00, a};
  endfunction

  // Memory: data appears exactly one cycle after the strobe, garbage otherwise.
  always @(posedge clk)
    bus.rd_data <= bus.rd_en ? mk(bus.rd_blk, bus.rd_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  blk;
    logic        last;
  } wrd_t;

  wrd_t        got[$];
  int          rd_cnt, vld_cnt, done_cnt, first_rd, first_vld, last_cyc, done_cyc;
  int          stall_err = 0;
  logic        pv_stall = 1'b0, p_abort = 1'b0;
  logic [31:0] pd;
  logic [3:0]  pb;
  logic        pl;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (bus.dout_valid) begin
        vld_cnt++;
        if (first_vld < 0) first_vld = cyc;
      end
      if (bus.dout_valid && bus.dout_ready) begin
        got.push_back('{bus.dout, bus.dout_blk, bus.dout_last});
        if (bus.dout_last) last_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pv_stall && !p_abort &&
          !(bus.dout_valid && bus.dout === pd && bus.dout_blk === pb && bus.dout_last === pl))
        stall_err++;
    end
    pv_stall = rst_n && bus.dout_valid && !bus.dout_ready;
    p_abort  = start;
    pd = bus.dout;
    pb = bus.dout_blk;
    pl = bus.dout_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkword(input string tag, input int i, input int b, input int a, input bit l);
    logic [63:0] obs;
    obs = '1;
    if (i < got.size()) obs = {27'd0, got[i].blk, got[i].data, got[i].last};
    chk(tag, obs, {27'd0, 4'(b), mk(4'(b), 6'(a)), l});
  endtask

  task automatic clr();
    got.delete();
    rd_cnt = 0; vld_cnt = 0; done_cnt = 0;
    first_rd = -1; first_vld = -1; last_cyc = -1; done_cyc = -1;
  endtask

  task automatic set_cnt(input int k, input int v);
    nent[k*CW +: CW] = CW'(v);
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    while (done_cnt == 0 && n < lim) begin
      tick();
      n++;
    end
    chk(tag, 64'(done_cnt > 0), 64'd1);
    repeat (3) tick();
  endtask

  int c0;

  initial begin
    rst_n = 1'b0; start = 1'b0; nent = '0; bus.dout_ready = 1'b1;
    clr();
    repeat (2) tick();
    chk("reset_outs", {bus.rd_en, bus.dout_valid, bus.dout_last, busy, done,
                       bus.rd_blk, bus.rd_addr, bus.dout_blk, bus.dout}, '0);
    rst_n = 1'b1;
    tick();

    // Priority order, latency and last/done placement
    nent = '0; set_cnt(0, 2); set_cnt(3, 1);
    clr(); c0 = cyc; start = 1'b1; tick(); start = 1'b0;
    wait_done("t1_timeout", 100);
    chk("t1_first_rd", 64'(first_rd), 64'(c0 + 2));
    chk("t1_first_vld", 64'(first_vld), 64'(c0 + 4));
    chk("t1_nwords", 64'(got.size()), 64'd3);
    chkword("t1_w0", 0, 0, 0, 1'b0);
    chkword("t1_w1", 1, 0, 1, 1'b0);
    chkword("t1_w2", 2, 3, 0, 1'b1);
    chk("t1_done_after_last", 64'(done_cyc), 64'(last_cyc + 1));
    chk("t1_done_cnt", 64'(done_cnt), 64'd1);

    // Empty event
    nent = '0;
    clr(); c0 = cyc; start = 1'b1; tick(); start = 1'b0;
    chk("t2_c1_busy_done", {busy, done}, 2'b10);
    tick();
    chk("t2_c2_busy_done", {busy, done}, 2'b11);
    tick();
    chk("t2_c3_busy_done", {busy, done}, 2'b00);
    chk("t2_no_rd", 64'(rd_cnt), 64'd0);
    chk("t2_no_vld", 64'(vld_cnt), 64'd0);
    chk("t2_done_cyc", 64'(done_cyc), 64'(c0 + 2));

    // Full block under toggling back-pressure
    nent = '0; set_cnt(11, 64);
    clr(); stall_err = 0; start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 2000 && done_cnt == 0; n++) begin
      bus.dout_ready = ~bus.dout_ready;
      tick();
    end
    bus.dout_ready = 1'b1;
    chk("t3_timeout", 64'(done_cnt > 0), 64'd1);
    repeat (3) tick();
    chk("t3_nwords", 64'(got.size()), 64'd64);
    for (int i = 0; i < 64; i++) chkword("t3_word", i, 11, i, i == 63);
    chk("t3_stable", 64'(stall_err), 64'd0);

    // Count above 2**AW is clamped
    nent = '0; set_cnt(5, 127);
    clr(); start = 1'b1; tick(); start = 1'b0;
    wait_done("t4_timeout", 400);
    chk("t4_reads", 64'(rd_cnt), 64'd64);
    chk("t4_nwords", 64'(got.size()), 64'd64);
    for (int i = 0; i < 64; i++) chkword("t4_word", i, 5, i, i == 63);

    // Restart during readout of block 0
    nent = '0; set_cnt(0, 4); set_cnt(2, 2);
    clr(); start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 50 && got.size() < 1; n++) tick();
    chk("t5_busy_mid", 64'(busy), 64'd1);
    nent = '0; set_cnt(1, 3);
    bus.dout_ready = 1'b0;
    clr(); start = 1'b1; tick(); start = 1'b0;
    bus.dout_ready = 1'b1;
    wait_done("t5_timeout", 100);
    repeat (10) tick();
    chk("t5_nwords", 64'(got.size()), 64'd3);
    chkword("t5_w0", 0, 1, 0, 1'b0);
    chkword("t5_w1", 1, 1, 1, 1'b0);
    chkword("t5_w2", 2, 1, 2, 1'b1);
    chk("t5_done_cnt", 64'(done_cnt), 64'd1);

    // Asynchronous reset mid-readout
    nent = '0; set_cnt(0, 10);
    clr(); start = 1'b1; tick(); start = 1'b0;
    for (int n = 0; n < 50 && got.size() < 2; n++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_reset", {bus.rd_en, bus.dout_valid, bus.dout_last, busy, done,
                           bus.rd_blk, bus.rd_addr, bus.dout_blk, bus.dout}, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    clr();
    repeat (20) tick();
    chk("t6_idle_rd", 64'(rd_cnt), 64'd0);
    chk("t6_idle_vld", 64'(vld_cnt), 64'd0);
    chk("t6_idle_busy", 64'(busy), 64'd0);
    nent = '0; set_cnt(4, 1);
    clr(); start = 1'b1; tick(); start = 1'b0;
    wait_done("t6_timeout", 100);
    chk("t6_nwords", 64'(got.size()), 64'd1);
    chkword("t6_w0", 0, 4, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
